if_id_hazard_stage: RTL and testbench
=====================================

Name: if_id_hazard_stage

Overview:
- IF/ID pipeline register with an integrated hazard detection unit. It sits directly upstream of the ID/EX register.
- Latches the fetched instruction and its PC values from IF, and holds them during stalls. Kills them on a taken branch or jump.
- Generates the stall signal that freezes the PC and drives the ID/EX register's Stall_in to insert a bubble.
- A small FSM covers the 2-cycle load-to-branch hazard.

Parameters:
- NOP_INSTR, 32'h0000_0000, instruction word loaded on reset or flush (sll $0,$0,0).
- STALL_CNT_W, 2, width of the remaining-stall counter.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Instruction_in  in  32  instruction word from instruction memory.
- PCOutput_in  in  32  PC of the fetched instruction.
- PCAdderOut_in  in  32  PC+4 of the fetched instruction.
- Flush_in  in  1  taken branch or jump resolved; discard the fetched instruction.
- ID_Branch  in  1  controller: the held instruction is a conditional branch.
- ID_UsesRt  in  1  controller: the held instruction reads rt as a source.
- EX_MemRead  in  2  MemRead of the instruction in EX; nonzero means a load.
- EX_RegWrite  in  2  RegWrite of the instruction in EX; nonzero means it writes a register.
- EX_WriteReg  in  5  destination register of the instruction in EX.
- MEM_MemRead  in  2  MemRead of the instruction in MEM.
- MEM_WriteReg  in  5  destination register of the instruction in MEM.
- Instruction_out  out  32  held instruction to ID.
- PCOutput_out  out  32  held PC.
- PCAdderOut_out  out  32  held PC+4.
- Valid_out  out  1  the held instruction is real, not a flush or reset NOP.
- Stall_out  out  1  hazard stall; drives ID/EX Stall_in.
- PCWrite_out  out  1  PC write enable; equals !Stall_out.

Behaviour:
- Reset (Reset=0, asynchronous): Instruction_out=NOP_INSTR, PC outputs=0, Valid_out=0, FSM=RUN, counter=0. Stall_out=0, PCWrite_out=1.
- Field extraction: rs=Instruction_out[25:21], rt=Instruction_out[20:16]. Register 0 never matches any destination.
- match_EX = EX_WriteReg!=0 and (EX_WriteReg==rs, or ID_UsesRt and EX_WriteReg==rt). match_MEM is defined the same way using MEM_WriteReg.
- Hazard terms, all qualified by Valid_out:
  - H_load: EX_MemRead!=0 and match_EX → 1 cycle.
  - H_brALU: ID_Branch, EX_RegWrite!=0, EX_MemRead==0, and match_EX → 1 cycle.
  - H_brLoadEX: ID_Branch, EX_MemRead!=0, and match_EX → 2 cycles.
  - H_brLoadMEM: ID_Branch, MEM_MemRead!=0, and match_MEM → 1 cycle.
- hazard_now = OR of all hazard terms.
- FSM states RUN and HOLD:
  - RUN: Stall_out=hazard_now. If H_brLoadEX, go to HOLD with counter=1; otherwise stay in RUN.
  - HOLD: Stall_out=1 unconditionally. The counter decrements each cycle; return to RUN when it reaches 0 after decrement. The hazard is re-evaluated in RUN.
- Stall_out is combinational from registered state and the EX/MEM inputs, with zero latency. The registers and FSM update on the rising edge.
- Register update priority, highest first:
  1. Flush_in=1: load NOP_INSTR, Valid=0, PC outputs=0, FSM=RUN, counter=0. Flush overrides any stall, including HOLD.
  2. Stall_out=1: hold all registers.
  3. Otherwise: load Instruction_in, PCOutput_in, PCAdderOut_in, and set Valid=1.
- Latency: 1 cycle from IF inputs to ID outputs when not stalled.
- Back-to-back hazards: RUN re-evaluates every cycle, so successive hazards chain with no dead cycle.
- Reset asserted mid-HOLD: immediate return to reset values; no residual stall.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs StallCycles_out[31:0] and FlushCount_out[31:0].
  - StallCycles_out increments on each edge where Stall_out=1 and Flush_in=0.
  - FlushCount_out increments on each edge where Flush_in=1.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counters are absent; the remaining behaviour is identical.

Decomposition:
- Shared package: NOP_INSTR, field bit positions (RS_MSB/LSB, RT_MSB/LSB), and the FSM state encoding (RUN=1'b0, HOLD=1'b1).
- One sub-module: hazard_detect. It is purely combinational, takes the instruction fields, controls and EX/MEM inputs, and outputs hazard_now and is_2cycle. The IF/ID registers and FSM stay in the top level.

Test Plan:
- Reset low for 2 cycles, then high; drive Instruction_in=32'h0109_5020 → Valid_out=0 during reset; after the first edge, Instruction_out=32'h0109_5020, Valid_out=1, Stall_out=0.
- Held add $10,$8,$9 with EX_MemRead=1, EX_WriteReg=8 → Stall_out=1 and PCWrite_out=0 for 1 cycle; outputs held; next cycle with EX_MemRead=0 → Stall_out=0.
- Held beq $8,$9 with ID_Branch=1 and load to $9 in EX → Stall_out=1 for 2 cycles (RUN→HOLD→RUN), then deasserts with MEM_MemRead=0.
- Flush_in=1 during the HOLD cycle → next edge gives Instruction_out=0, Valid_out=0, Stall_out=0, FSM=RUN.
- EX_WriteReg=0, EX_MemRead=1, with rs=0 held → no stall.
- HAZARD_STATS_EN: 3 stall cycles and 2 flushes → StallCycles_out=3, FlushCount_out=2; Reset low → both counters return to 0.

Source files
------------

// File: rtl/if_id_hazard_stage_pkg.sv
// Shared constants for the IF/ID stage: reset/flush instruction word, register field
// positions and the load-to-branch FSM encoding.
package if_id_hazard_stage_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam int          STALL_CNT_W = 2;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/if_id_hazard_stage_if.sv
// IF/ID stage bus: fetch-side inputs, ID/EX/MEM hazard sideband and the held outputs.
// The master side drives the fetch and hazard inputs; the slave side is the stage itself.
interface if_id_hazard_stage_if;

  logic [31:0] Instruction_in;
  logic [31:0] PCOutput_in;
  logic [31:0] PCAdderOut_in;
  logic        Flush_in;
  logic        ID_Branch;
  logic        ID_UsesRt;
  logic [1:0]  EX_MemRead;
  logic [1:0]  EX_RegWrite;
  logic [4:0]  EX_WriteReg;
  logic [1:0]  MEM_MemRead;
  logic [4:0]  MEM_WriteReg;

  logic [31:0] Instruction_out;
  logic [31:0] PCOutput_out;
  logic [31:0] PCAdderOut_out;
  logic        Valid_out;
  logic        Stall_out;
  logic        PCWrite_out;

  modport master (
    output Instruction_in, PCOutput_in, PCAdderOut_in, Flush_in,
           ID_Branch, ID_UsesRt, EX_MemRead, EX_RegWrite, EX_WriteReg,
           MEM_MemRead, MEM_WriteReg,
    input  Instruction_out, PCOutput_out, PCAdderOut_out, Valid_out,
           Stall_out, PCWrite_out
  );

  modport slave (
    input  Instruction_in, PCOutput_in, PCAdderOut_in, Flush_in,
           ID_Branch, ID_UsesRt, EX_MemRead, EX_RegWrite, EX_WriteReg,
           MEM_MemRead, MEM_WriteReg,
    output Instruction_out, PCOutput_out, PCAdderOut_out, Valid_out,
           Stall_out, PCWrite_out
  );

endinterface

// File: rtl/if_id_hazard_stage_hazard_detect.sv
// Combinational hazard detection for the instruction held in IF/ID against EX and MEM.
// Register 0 is never treated as a real destination.
module hazard_detect (
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       valid_i,
  input  logic       idBranch_i,
  input  logic       idUsesRt_i,
  input  logic [1:0] exMemRead_i,
  input  logic [1:0] exRegWrite_i,
  input  logic [4:0] exWriteReg_i,
  input  logic [1:0] memMemRead_i,
  input  logic [4:0] memWriteReg_i,
  output logic       hazardNow_o,
  output logic       is2Cycle_o
);

  logic matchEx, matchMem;
  logic hLoad, hBrAlu, hBrLoadEx, hBrLoadMem;

  // A branch behind a load still in EX needs the value two cycles later, hence is2Cycle.
  always_comb begin
    matchEx    = (exWriteReg_i != 5'd0) &&
                 ((exWriteReg_i == rs_i) || (idUsesRt_i && (exWriteReg_i == rt_i)));
    matchMem   = (memWriteReg_i != 5'd0) &&
                 ((memWriteReg_i == rs_i) || (idUsesRt_i && (memWriteReg_i == rt_i)));
    hLoad      = valid_i && (exMemRead_i != 2'b00) && matchEx;
    hBrAlu     = valid_i && idBranch_i && (exRegWrite_i != 2'b00) &&
                 (exMemRead_i == 2'b00) && matchEx;
    hBrLoadEx  = valid_i && idBranch_i && (exMemRead_i != 2'b00) && matchEx;
    hBrLoadMem = valid_i && idBranch_i && (memMemRead_i != 2'b00) && matchMem;
    hazardNow_o = hLoad | hBrAlu | hBrLoadEx | hBrLoadMem;
    is2Cycle_o  = hBrLoadEx;
  end

endmodule

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with hazard stall generation and a RUN/HOLD FSM for the
// 2-cycle load-to-branch case. Define HAZARD_STATS_EN to add stall/flush counters.
module if_id_hazard_stage #(
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
  parameter int          STALL_CNT_W = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  if_id_hazard_stage_if.slave  bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]          StallCycles_out,
  output logic [31:0]          FlushCount_out
`endif
);

  import if_id_hazard_stage_pkg::*;

  localparam logic [STALL_CNT_W-1:0] CntOne = STALL_CNT_W'(1);

  logic [31:0]            instr_q, pc_q, pcAdd_q;
  logic                   valid_q;
  state_e                 state_q, state_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   hazardNow, is2Cycle, stall;

  hazard_detect u_hazardDetect (
    .rs_i          (instr_q[RS_MSB:RS_LSB]),
    .rt_i          (instr_q[RT_MSB:RT_LSB]),
    .valid_i       (valid_q),
    .idBranch_i    (bus.ID_Branch),
    .idUsesRt_i    (bus.ID_UsesRt),
    .exMemRead_i   (bus.EX_MemRead),
    .exRegWrite_i  (bus.EX_RegWrite),
    .exWriteReg_i  (bus.EX_WriteReg),
    .memMemRead_i  (bus.MEM_MemRead),
    .memWriteReg_i (bus.MEM_WriteReg),
    .hazardNow_o   (hazardNow),
    .is2Cycle_o    (is2Cycle)
  );

  // HOLD stalls blindly until the counter drains; a flush always wins and returns to RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        stall = hazardNow;
        if (is2Cycle) begin
          state_d = HOLD;
          cnt_d   = CntOne;
        end
      end
      HOLD: begin
        stall = 1'b1;
        cnt_d = cnt_q - CntOne;
        if (cnt_d == '0) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (bus.Flush_in) begin
      state_d = RUN;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 32'd0;
      pcAdd_q <= 32'd0;
      valid_q <= 1'b0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (bus.Flush_in) begin
        instr_q <= NOP_INSTR;
        pc_q    <= 32'd0;
        pcAdd_q <= 32'd0;
        valid_q <= 1'b0;
      end else if (!stall) begin
        instr_q <= bus.Instruction_in;
        pc_q    <= bus.PCOutput_in;
        pcAdd_q <= bus.PCAdderOut_in;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.Instruction_out = instr_q;
  assign bus.PCOutput_out    = pc_q;
  assign bus.PCAdderOut_out  = pcAdd_q;
  assign bus.Valid_out       = valid_q;
  assign bus.Stall_out       = stall;
  assign bus.PCWrite_out     = !stall;

`ifdef HAZARD_STATS_EN
  logic [31:0] stallCycles_q, flushCount_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stallCycles_q <= 32'd0;
      flushCount_q  <= 32'd0;
    end else begin
      if (stall && !bus.Flush_in && (stallCycles_q != 32'hFFFF_FFFF))
        stallCycles_q <= stallCycles_q + 32'd1;
      if (bus.Flush_in && (flushCount_q != 32'hFFFF_FFFF))
        flushCount_q <= flushCount_q + 32'd1;
    end
  end

  assign StallCycles_out = stallCycles_q;
  assign FlushCount_out  = flushCount_q;
`endif

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Self-checking bench for if_id_hazard_stage: directed scenarios plus randomized traffic
// compared against a stall-budget reference model.
module tb_if_id_hazard_stage;

  import if_id_hazard_stage_pkg::*;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  int   passCount  = 0;
  int   checkCount = 0;

  always #5 Clk = ~Clk;

  if_id_hazard_stage_if bus ();

`ifdef HAZARD_STATS_EN
  logic [31:0] StallCycles_out, FlushCount_out;
`endif

  if_id_hazard_stage dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
`ifdef HAZARD_STATS_EN
    ,
    .StallCycles_out (StallCycles_out),
    .FlushCount_out  (FlushCount_out)
`endif
  );

  // Reference model: held register contents plus the number of extra stall cycles owed.
  logic [31:0] mInstr, mPc, mPc4;
  logic        mValid;
  int          mOwed;
  int          mStallCycles, mFlushes;

  function automatic logic refMatch(input logic [4:0] dst);
    return (dst != 5'd0) &&
           ((dst == mInstr[25:21]) || (bus.ID_UsesRt && (dst == mInstr[20:16])));
  endfunction

  // Total stall cycles the held instruction needs given the current EX/MEM contents.
  function automatic int refNeed();
    int n;
    n = 0;
    if (!mValid) return 0;
    if ((bus.EX_MemRead != 0) && refMatch(bus.EX_WriteReg)) n = 1;
    if (bus.ID_Branch && (bus.EX_RegWrite != 0) && (bus.EX_MemRead == 0) &&
        refMatch(bus.EX_WriteReg)) n = 1;
    if (bus.ID_Branch && (bus.MEM_MemRead != 0) && refMatch(bus.MEM_WriteReg)) n = 1;
    if (bus.ID_Branch && (bus.EX_MemRead != 0) && refMatch(bus.EX_WriteReg)) n = 2;
    return n;
  endfunction

  function automatic logic refStall();
    return (mOwed > 0) || (refNeed() > 0);
  endfunction

  task automatic modelReset();
    mInstr = NOP_INSTR; mPc = 0; mPc4 = 0; mValid = 0; mOwed = 0;
    mStallCycles = 0; mFlushes = 0;
  endtask

  task automatic modelEdge();
    int  need;
    logic st;
    need = refNeed();
    st   = (mOwed > 0) || (need > 0);
    if (st && !bus.Flush_in) mStallCycles++;
    if (bus.Flush_in) mFlushes++;
    if (bus.Flush_in) begin
      mInstr = NOP_INSTR; mPc = 0; mPc4 = 0; mValid = 0; mOwed = 0;
    end else if (st) begin
      if (mOwed > 0) mOwed--;
      else mOwed = need - 1;
    end else begin
      mInstr = bus.Instruction_in; mPc = bus.PCOutput_in; mPc4 = bus.PCAdderOut_in;
      mValid = 1;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic flush, input logic br, input logic usesRt,
                               input logic [1:0] exRd, input logic [1:0] exWr,
                               input logic [4:0] exReg, input logic [1:0] memRd,
                               input logic [4:0] memReg);
    bus.Instruction_in = instr;
    bus.PCOutput_in    = pc;
    bus.PCAdderOut_in  = pc + 32'd4;
    bus.Flush_in       = flush;
    bus.ID_Branch      = br;
    bus.ID_UsesRt      = usesRt;
    bus.EX_MemRead     = exRd;
    bus.EX_RegWrite    = exWr;
    bus.EX_WriteReg    = exReg;
    bus.MEM_MemRead    = memRd;
    bus.MEM_WriteReg   = memReg;
  endtask

  task automatic test_reset();
    applyStimulus(32'h0109_5020, 32'h100, 0, 0, 1, 2'b00, 2'b00, 5'd0, 2'b00, 5'd0);
    repeat (2) @(posedge Clk);
    #1;
    checkCount++;
    if (bus.Valid_out !== 1'b0)
      $display("[TB] FAIL reset_valid: got %b expected 0", bus.Valid_out);
    else passCount++;
    checkCount++;
    if (bus.Instruction_out !== 32'h0 || bus.PCOutput_out !== 32'h0 || bus.PCAdderOut_out !== 32'h0)
      $display("[TB] FAIL reset_regs: got %h/%h/%h expected 0/0/0",
               bus.Instruction_out, bus.PCOutput_out, bus.PCAdderOut_out);
    else passCount++;
    checkCount++;
    if (bus.Stall_out !== 1'b0 || bus.PCWrite_out !== 1'b1)
      $display("[TB] FAIL reset_stall: got stall=%b pcwrite=%b expected 0/1",
               bus.Stall_out, bus.PCWrite_out);
    else passCount++;
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    checkCount++;
    if (bus.Instruction_out !== 32'h0109_5020 || bus.Valid_out !== 1'b1 || bus.PCOutput_out !== 32'h100)
      $display("[TB] FAIL first_load: got %h valid=%b pc=%h expected 01095020/1/00000100",
               bus.Instruction_out, bus.Valid_out, bus.PCOutput_out);
    else passCount++;
    #1;
    checkCount++;
    if (bus.Stall_out !== 1'b0)
      $display("[TB] FAIL first_nostall: got %b expected 0", bus.Stall_out);
    else passCount++;
  endtask

  task automatic test_load_use();
    applyStimulus(32'h1109_0004, 32'h200, 0, 0, 1, 2'b01, 2'b01, 5'd8, 2'b00, 5'd0);
    #1;
    checkCount++;
    if (bus.Stall_out !== 1'b1 || bus.PCWrite_out !== 1'b0)
      $display("[TB] FAIL load_use_stall: got stall=%b pcwrite=%b expected 1/0",
               bus.Stall_out, bus.PCWrite_out);
    else passCount++;
    @(posedge Clk);
    #1;
    checkCount++;
    if (bus.Instruction_out !== 32'h0109_5020 || bus.PCOutput_out !== 32'h100)
      $display("[TB] FAIL load_use_hold: got %h pc=%h expected 01095020/00000100",
               bus.Instruction_out, bus.PCOutput_out);
    else passCount++;
    bus.EX_MemRead = 2'b00;
    #1;
    checkCount++;
    if (bus.Stall_out !== 1'b0 || bus.PCWrite_out !== 1'b1)
      $display("[TB] FAIL load_use_release: got stall=%b pcwrite=%b expected 0/1",
               bus.Stall_out, bus.PCWrite_out);
    else passCount++;
    @(posedge Clk);
    #1;
    checkCount++;
    if (bus.Instruction_out !== 32'h1109_0004 || bus.PCAdderOut_out !== 32'h204)
      $display("[TB] FAIL load_use_advance: got %h pc4=%h expected 11090004/00000204",
               bus.Instruction_out, bus.PCAdderOut_out);
    else passCount++;
  endtask

  task automatic test_branch_load();
    applyStimulus(32'h0000_1111, 32'h300, 0, 1, 1, 2'b01, 2'b01, 5'd9, 2'b00, 5'd0);
    #1;
    checkCount++;
    if (bus.Stall_out !== 1'b1)
      $display("[TB] FAIL brload_stall1: got %b expected 1", bus.Stall_out);
    else passCount++;
    @(posedge Clk);
    #1;
    bus.EX_MemRead = 2'b00; bus.EX_RegWrite = 2'b00; bus.EX_WriteReg = 5'd0;
    bus.MEM_MemRead = 2'b00; bus.MEM_WriteReg = 5'd9;
    #1;
    checkCount++;
    if (bus.Stall_out !== 1'b1 || bus.Instruction_out !== 32'h1109_0004)
      $display("[TB] FAIL brload_stall2: got stall=%b instr=%h expected 1/11090004",
               bus.Stall_out, bus.Instruction_out);
    else passCount++;
    @(posedge Clk);
    #2;
    checkCount++;
    if (bus.Stall_out !== 1'b0 || bus.PCWrite_out !== 1'b1 || bus.Instruction_out !== 32'h1109_0004)
      $display("[TB] FAIL brload_release: got stall=%b pcwrite=%b instr=%h expected 0/1/11090004",
               bus.Stall_out, bus.PCWrite_out, bus.Instruction_out);
    else passCount++;
  endtask

  task automatic test_flush_hold();
    bus.EX_MemRead = 2'b01; bus.EX_RegWrite = 2'b01; bus.EX_WriteReg = 5'd9;
    @(posedge Clk);
    #1;
    bus.Flush_in = 1'b1;
    #1;
    checkCount++;
    if (bus.Stall_out !== 1'b1)
      $display("[TB] FAIL flush_hold_stall: got %b expected 1", bus.Stall_out);
    else passCount++;
    @(posedge Clk);
    #1;
    bus.Flush_in = 1'b0;
    checkCount++;
    if (bus.Instruction_out !== 32'h0 || bus.Valid_out !== 1'b0 ||
        bus.PCOutput_out !== 32'h0 || bus.PCAdderOut_out !== 32'h0)
      $display("[TB] FAIL flush_regs: got %h valid=%b pc=%h pc4=%h expected 0/0/0/0",
               bus.Instruction_out, bus.Valid_out, bus.PCOutput_out, bus.PCAdderOut_out);
    else passCount++;
    #1;
    checkCount++;
    if (bus.Stall_out !== 1'b0)
      $display("[TB] FAIL flush_run: got stall=%b expected 0", bus.Stall_out);
    else passCount++;
  endtask

  task automatic test_zero_reg();
    applyStimulus(32'h0000_4020, 32'h400, 0, 0, 1, 2'b00, 2'b00, 5'd0, 2'b00, 5'd0);
    @(posedge Clk);
    #1;
    checkCount++;
    if (bus.Instruction_out !== 32'h0000_4020 || bus.Valid_out !== 1'b1)
      $display("[TB] FAIL zero_load: got %h valid=%b expected 00004020/1",
               bus.Instruction_out, bus.Valid_out);
    else passCount++;
    applyStimulus(32'h0, 32'h404, 0, 1, 1, 2'b01, 2'b01, 5'd0, 2'b01, 5'd0);
    #1;
    checkCount++;
    if (bus.Stall_out !== 1'b0)
      $display("[TB] FAIL zero_reg_nostall: got %b expected 0", bus.Stall_out);
    else passCount++;
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    Reset = 1'b0;
    #1;
    checkCount++;
    if (StallCycles_out !== 32'd0 || FlushCount_out !== 32'd0)
      $display("[TB] FAIL stats_reset: got %0d/%0d expected 0/0", StallCycles_out, FlushCount_out);
    else passCount++;
    applyStimulus(32'h0109_5020, 32'h500, 0, 0, 1, 2'b00, 2'b00, 5'd0, 2'b00, 5'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    bus.EX_MemRead = 2'b01; bus.EX_WriteReg = 5'd8;
    repeat (3) @(posedge Clk);
    #1;
    bus.EX_MemRead = 2'b00; bus.EX_WriteReg = 5'd0; bus.Flush_in = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    bus.Flush_in = 1'b0;
    checkCount++;
    if (StallCycles_out !== 32'd3 || FlushCount_out !== 32'd2)
      $display("[TB] FAIL stats_count: got %0d/%0d expected 3/2", StallCycles_out, FlushCount_out);
    else passCount++;
    Reset = 1'b0;
    #1;
    checkCount++;
    if (StallCycles_out !== 32'd0 || FlushCount_out !== 32'd0)
      $display("[TB] FAIL stats_clear: got %0d/%0d expected 0/0", StallCycles_out, FlushCount_out);
    else passCount++;
  endtask
`endif

  task automatic test_random();
    logic [31:0] r;
    Reset = 1'b0;
    modelReset();
    applyStimulus(32'h0, 32'h0, 0, 0, 0, 2'b00, 2'b00, 5'd0, 2'b00, 5'd0);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      r[25:21] = 5'($urandom_range(0, 3));
      r[20:16] = 5'($urandom_range(0, 3));
      applyStimulus(r, $urandom, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) != 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) != 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    5'($urandom_range(0, 3)));
      #1;
      checkCount++;
      if (bus.Stall_out !== refStall() || bus.PCWrite_out !== !refStall())
        $display("[TB] FAIL rand_stall[%0d]: got stall=%b pcwrite=%b expected stall=%b",
                 i, bus.Stall_out, bus.PCWrite_out, refStall());
      else passCount++;
      modelEdge();
      @(posedge Clk);
      #1;
      checkCount++;
      if (bus.Instruction_out !== mInstr || bus.PCOutput_out !== mPc ||
          bus.PCAdderOut_out !== mPc4 || bus.Valid_out !== mValid)
        $display("[TB] FAIL rand_regs[%0d]: got %h/%h/%h/%b expected %h/%h/%h/%b", i,
                 bus.Instruction_out, bus.PCOutput_out, bus.PCAdderOut_out, bus.Valid_out,
                 mInstr, mPc, mPc4, mValid);
      else passCount++;
`ifdef HAZARD_STATS_EN
      checkCount++;
      if (StallCycles_out !== 32'(mStallCycles) || FlushCount_out !== 32'(mFlushes))
        $display("[TB] FAIL rand_stats[%0d]: got %0d/%0d expected %0d/%0d", i,
                 StallCycles_out, FlushCount_out, mStallCycles, mFlushes);
      else passCount++;
`endif
    end
  endtask

  initial begin
    $display("[TB] starting if_id_hazard_stage bench");
    test_reset();
    test_load_use();
    test_branch_load();
    test_flush_hold();
    test_zero_reg();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
